// File: rtl/imu_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imu_spi_responder                                          |
// | Description : SPI mode-3 responder emulating an IMU. Decodes R/W, MS and |
// |               6-bit address from the command byte, serves WHO_AM_I, 24   |
// |               scratch bytes and a per-frame snapshot of the XYZ samples. |
// |               Optional macro SPI_AUTOINC_EN honours the MS bit.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imu_spi_responder #(
    parameter logic [7:0] WHO_AM_I    = 8'h6C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CS,
    input  logic        SPC,
    input  logic        SDI,
    output logic        SDO,
    output logic        sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_spc_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_cs_hist;
    logic                   r_spc_hist;

    logic       w_cs;
    logic       w_spc;
    logic       w_sdi;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_spc_rise;
    logic       w_spc_fall;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_tx;
    logic       r_rw;
`ifdef SPI_AUTOINC_EN
    logic       r_ms;
`endif
    logic [5:0] r_addr;

    logic [7:0]  r_scratch [0:23];
    logic [15:0] r_snap_x;
    logic [15:0] r_snap_y;
    logic [15:0] r_snap_z;

    logic [7:0] w_rx_byte;
    logic       w_cmd_done;
    logic       w_byte_done;
    logic [5:0] w_next_addr;
    logic [5:0] w_load_addr;
    logic [7:0] w_load_data;
    logic [4:0] w_load_idx;
    logic [4:0] w_wr_idx;
    logic       w_writable;
    logic       w_write_commit;

    // Synchronise the SPI pins into clk and keep one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs_sync  <= '1;
            r_spc_sync <= '1;
            r_sdi_sync <= '1;
            r_cs_hist  <= 1'b1;
            r_spc_hist <= 1'b1;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_spc_sync <= {r_spc_sync[SYNC_STAGES-2:0], SPC};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
            r_cs_hist  <= r_cs_sync[SYNC_STAGES-1];
            r_spc_hist <= r_spc_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_spc      = r_spc_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_hist & ~w_cs;
    assign w_cs_rise  = ~r_cs_hist & w_cs;
    // SPC edges only count inside a frame; IDLE covers the CS-high case
    assign w_spc_rise = ~r_spc_hist & w_spc & (r_state != IDLE);
    assign w_spc_fall = r_spc_hist & ~w_spc & (r_state != IDLE);

    assign w_rx_byte   = {r_shift, w_sdi};
    assign w_cmd_done  = (r_state == CMD)  && w_spc_rise && (r_bit_cnt == 3'd7);
    assign w_byte_done = (r_state == DATA) && w_spc_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_AUTOINC_EN
    assign w_next_addr = r_ms ? (r_addr + 6'd1) : r_addr;
`else
    assign w_next_addr = r_addr;
`endif

    // The byte to preload into TX: command address on the command byte, else the next address
    assign w_load_addr = (r_state == CMD) ? w_rx_byte[5:0] : w_next_addr;
    // Scratch index: address minus 0x10, valid for 0x10..0x27 using modulo-32 arithmetic
    assign w_load_idx  = w_load_addr[4:0] - 5'd16;
    assign w_wr_idx    = r_addr[4:0] - 5'd16;
    assign w_writable  = (r_addr >= 6'h10) && (r_addr <= 6'h27);
    assign w_write_commit = w_byte_done && !r_rw && w_writable;

    // Register map read decode
    always_comb begin
        w_load_data = 8'h00;
        case (w_load_addr)
            6'h0F:   w_load_data = WHO_AM_I;
            6'h28:   w_load_data = r_snap_x[7:0];
            6'h29:   w_load_data = r_snap_x[15:8];
            6'h2A:   w_load_data = r_snap_y[7:0];
            6'h2B:   w_load_data = r_snap_y[15:8];
            6'h2C:   w_load_data = r_snap_z[7:0];
            6'h2D:   w_load_data = r_snap_z[15:8];
            default: begin
                if ((w_load_addr >= 6'h10) && (w_load_addr <= 6'h27)) begin
                    w_load_data = r_scratch[w_load_idx];
                end
            end
        endcase
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame next-state logic; CS rising always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_cs_fall) w_state_next = CMD;
            CMD: begin
                if (w_cs_rise)       w_state_next = IDLE;
                else if (w_cmd_done) w_state_next = DATA;
            end
            DATA: if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bit counter, command decode, TX shifting and write/frame strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_tx       <= 8'h00;
            r_rw       <= 1'b0;
`ifdef SPI_AUTOINC_EN
            r_ms       <= 1'b0;
`endif
            r_addr     <= 6'd0;
            SDO        <= 1'b0;
            sdo_oe     <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            wr_valid   <= 1'b0;
            frame_done <= w_cs_rise && ((r_state == DATA) || w_cmd_done);
            // A completed write byte commits even if CS rises in the same cycle
            if (w_write_commit) begin
                wr_valid <= 1'b1;
                wr_addr  <= r_addr;
                wr_data  <= w_rx_byte;
            end
            if ((r_state == IDLE) || w_cs_rise) begin
                r_bit_cnt <= 3'd0;
                SDO       <= 1'b0;
                sdo_oe    <= 1'b0;
            end else if (w_spc_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= w_rx_byte[6:0];
                if (w_cmd_done) begin
                    r_rw   <= w_rx_byte[7];
`ifdef SPI_AUTOINC_EN
                    r_ms   <= w_rx_byte[6];
`endif
                    r_addr <= w_rx_byte[5:0];
                    r_tx   <= w_load_data;
                end else if (w_byte_done) begin
                    r_addr <= w_next_addr;
                    r_tx   <= w_load_data;
                end
            end else if (w_spc_fall && (r_state == DATA) && r_rw) begin
                SDO    <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
                sdo_oe <= 1'b1;
            end
        end
    end

    // Writable scratch bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 24; i++) begin
                r_scratch[i] <= 8'h00;
            end
        end else if (w_write_commit) begin
            r_scratch[w_wr_idx] <= w_rx_byte;
        end
    end

    // Snapshot of the live samples at frame start; deliberately survives reset
    always_ff @(posedge clk) begin
        if (w_cs_fall) begin
            r_snap_x <= sample_x;
            r_snap_y <= sample_y;
            r_snap_z <= sample_z;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imu_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imu_spi_responder                                       |
// | Description : Scoreboard bench for imu_spi_responder. Stimulus pushes    |
// |               expected read bytes, writes and frame counts; monitors pop |
// |               and compare. Expectations follow SPI_AUTOINC_EN.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_imu_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CS = 1'b1;
    logic        SPC = 1'b1;
    logic        SDI = 1'b0;
    logic        SDO;
    logic        sdo_oe;
    logic [15:0] sample_x = 16'h0000;
    logic [15:0] sample_y = 16'h0000;
    logic [15:0] sample_z = 16'h0000;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    logic [7:0]  rd_exp[$];
    logic [13:0] wr_exp[$];
    int          frames_exp = 0;
    int          frames_seen = 0;
    logic [7:0]  txbuf[8];
    logic [7:0]  rd_sh = 8'h00;
    int          rd_bits = 0;

    imu_spi_responder #(
        .WHO_AM_I   (8'h6C),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CS        (CS),
        .SPC       (SPC),
        .SDI       (SDI),
        .SDO       (SDO),
        .sdo_oe    (sdo_oe),
        .sample_x  (sample_x),
        .sample_y  (sample_y),
        .sample_z  (sample_z),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: master samples SDO on SPC rising edges while the responder drives
    initial begin
        forever begin
            @(posedge SPC);
            if (sdo_oe === 1'b1) begin
                rd_sh = {rd_sh[6:0], SDO};
                rd_bits++;
                if (rd_bits == 8) begin
                    rd_bits = 0;
                    if (rd_exp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rd_unexpected: got %0h expected none", rd_sh);
                    end else begin
                        check("rd_byte", {24'd0, rd_sh}, {24'd0, rd_exp.pop_front()});
                    end
                end
            end
        end
    end

    // Write and frame_done monitor
    initial begin
        forever begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                if (wr_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected none", wr_addr, wr_data);
                end else begin
                    check("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, wr_exp.pop_front()});
                end
            end
            if (frame_done === 1'b1) frames_seen++;
        end
    end

    // One mode-3 frame: SDI changes on SPC fall, responder samples on SPC rise
    task automatic spi_frame(input int nbytes, input int extra_bits);
        logic [7:0] cur;
        int total;
        total = nbytes * 8 + extra_bits;
        @(negedge clk);
        CS = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < total; i++) begin
            cur = txbuf[i / 8];
            SPC = 1'b0;
            SDI = cur[7 - (i % 8)];
            repeat (8) @(negedge clk);
            SPC = 1'b1;
            repeat (8) @(negedge clk);
        end
        CS = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic settle(input string name);
        check({name, "_frames"}, frames_seen, frames_exp);
        check({name, "_rdq"}, rd_exp.size(), 0);
        check({name, "_wrq"}, wr_exp.size(), 0);
        check({name, "_oe_idle"}, {31'd0, sdo_oe}, 0);
        check({name, "_sdo_idle"}, {31'd0, SDO}, 0);
        rd_exp.delete();
        wr_exp.delete();
        rd_bits = 0;
    endtask

    initial begin
        // Reset with CS idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sdo", {31'd0, SDO}, 0);
        check("rst_oe", {31'd0, sdo_oe}, 0);
        check("rst_wr_valid", {31'd0, wr_valid}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_wr_addr", {26'd0, wr_addr}, 0);
        check("rst_wr_data", {24'd0, wr_data}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Scratch is zero after reset
        txbuf[0] = 8'h90; txbuf[1] = 8'h00;
        rd_exp.push_back(8'h00);
        frames_exp++;
        spi_frame(2, 0);
        settle("rst_read");

        // WHO_AM_I
        txbuf[0] = 8'h8F; txbuf[1] = 8'h00;
        rd_exp.push_back(8'h6C);
        frames_exp++;
        spi_frame(2, 0);
        settle("who_am_i");

        // Burst snapshot read; samples change mid-frame and must not disturb the data
        sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h0F0F;
        txbuf[0] = 8'hE8;
        for (int i = 1; i < 7; i++) txbuf[i] = 8'h00;
`ifdef SPI_AUTOINC_EN
        rd_exp.push_back(8'h34); rd_exp.push_back(8'h12);
        rd_exp.push_back(8'hCD); rd_exp.push_back(8'hAB);
        rd_exp.push_back(8'h0F); rd_exp.push_back(8'h0F);
`else
        for (int i = 0; i < 6; i++) rd_exp.push_back(8'h34);
`endif
        frames_exp++;
        fork
            spi_frame(7, 0);
            begin
                repeat (60) @(negedge clk);
                sample_x = 16'hFFFF; sample_y = 16'hFFFF; sample_z = 16'hFFFF;
            end
        join
        settle("burst");

        // Write two bytes then read them back
        txbuf[0] = 8'h50; txbuf[1] = 8'hA5; txbuf[2] = 8'h5A;
        wr_exp.push_back({6'h10, 8'hA5});
`ifdef SPI_AUTOINC_EN
        wr_exp.push_back({6'h11, 8'h5A});
`else
        wr_exp.push_back({6'h10, 8'h5A});
`endif
        frames_exp++;
        spi_frame(3, 0);
        settle("write");

        txbuf[0] = 8'hD0; txbuf[1] = 8'h00; txbuf[2] = 8'h00;
`ifdef SPI_AUTOINC_EN
        rd_exp.push_back(8'hA5); rd_exp.push_back(8'h5A);
`else
        rd_exp.push_back(8'h5A); rd_exp.push_back(8'h5A);
`endif
        frames_exp++;
        spi_frame(3, 0);
        settle("readback");

        // Abort after four data bits: no write, frame_done still pulses
        txbuf[0] = 8'h12; txbuf[1] = 8'hFF;
        frames_exp++;
        spi_frame(1, 4);
        settle("abort");

        txbuf[0] = 8'h92; txbuf[1] = 8'h00;
        rd_exp.push_back(8'h00);
        frames_exp++;
        spi_frame(2, 0);
        settle("abort_read");

        // Wrap 0x3F -> 0x00, neither address writable
        txbuf[0] = 8'h7F; txbuf[1] = 8'h11; txbuf[2] = 8'h22;
        frames_exp++;
        spi_frame(3, 0);
        settle("wrap_write");

        txbuf[0] = 8'hFF; txbuf[1] = 8'h00; txbuf[2] = 8'h00;
        rd_exp.push_back(8'h00); rd_exp.push_back(8'h00);
        frames_exp++;
        spi_frame(3, 0);
        settle("wrap_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
